// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: FIFO-buffered UART RX command decoder driving the green LED and UART TX replies; RX byte -> LED/first TX DV in 3 cycles.
// Replies are paced by TX Done/Active; RX bytes dropped on a full FIFO set sticky o_Overflow. UART_CMD_CRLF_EN appends CR/LF to replies.
module uart_cmd_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  output logic       o_LED_G,
  output logic       o_Busy,
  output logic       o_Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef UART_CMD_CRLF_EN
  localparam logic [1:0] LAST_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_IDX = 2'd0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_SEND, S_WAIT, S_GAP} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic          ovf_q, ovf_d;

  logic [7:0] cmd_q, cmd_d;
  logic [7:0] first_q, first_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [1:0] idx_q, idx_d;
  logic       tx_dv_q, tx_dv_d;
  logic       led_q, led_d;

  logic [7:0] first_c, reply_c;
  logic       led_c, ignore_c;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop  = (state_q == S_IDLE) && (count_q != '0) && !i_TX_Active;
  assign push = i_RX_DV && ((count_q != DEPTH_C) || pop);
  assign ovf_d = ovf_q | (i_RX_DV & ~push);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_RX_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    first_c  = 8'h45;
    led_c    = led_q;
    ignore_c = 1'b0;
    case (cmd_q)
      8'h31:        begin led_c = 1'b0;   first_c = 8'h4B; end
      8'h30:        begin led_c = 1'b1;   first_c = 8'h4B; end
      8'h74:        begin led_c = ~led_q; first_c = 8'h4B; end
      8'h3F:        first_c = led_q ? 8'h30 : 8'h31;
      8'h0D, 8'h0A: ignore_c = 1'b1;
      default:      first_c = 8'h45;
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    reply_c = first_q;
      2'd1:    reply_c = 8'h0D;
      default: reply_c = 8'h0A;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pop) state_d = S_DECODE;
      S_DECODE: state_d = ignore_c ? S_IDLE : S_SEND;
      S_SEND:   state_d = S_WAIT;
      S_WAIT:   if (i_TX_Done) state_d = (idx_q == LAST_IDX) ? S_IDLE : S_GAP;
      S_GAP:    if (!i_TX_Active) state_d = S_SEND;
      default:  state_d = S_IDLE;
    endcase
  end

  // DV and byte are registered on entry to SEND so the pulse lines up with the SEND cycle.
  always_comb begin
    cmd_d     = cmd_q;
    led_d     = led_q;
    first_d   = first_q;
    idx_d     = idx_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = (state_d == S_SEND);
    o_Busy    = (state_q != S_IDLE);
    if (pop) cmd_d = mem_q[rd_ptr_q];
    case (state_q)
      S_DECODE: begin
        led_d   = led_c;
        first_d = first_c;
        idx_d   = 2'd0;
        if (!ignore_c) tx_byte_d = first_c;
      end
      S_WAIT:  if (i_TX_Done) idx_d = idx_q + 2'd1;
      S_GAP:   if (!i_TX_Active) tx_byte_d = reply_c;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cmd_q     <= 8'h00;
      first_q   <= 8'h00;
      tx_byte_q <= 8'h00;
      idx_q     <= 2'd0;
      tx_dv_q   <= 1'b0;
      led_q     <= 1'b1;
    end else begin
      cmd_q     <= cmd_d;
      first_q   <= first_d;
      tx_byte_q <= tx_byte_d;
      idx_q     <= idx_d;
      tx_dv_q   <= tx_dv_d;
      led_q     <= led_d;
    end
  end

  assign o_TX_DV    = tx_dv_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_LED_G    = led_q;
  assign o_Overflow = ovf_q;

endmodule
